// File: rtl/sim_ctrl_pkg.sv
// Shared types and constants for the simulation run controller.
// Holds the run-state encoding, done-cause codes and the ECALL instruction word.
package sim_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RST_HOLD = 2'd1,
        S_RUN      = 2'd2,
        S_DONE     = 2'd3
    } run_state_t;

    localparam logic [1:0]  CAUSE_NONE    = 2'd0;
    localparam logic [1:0]  CAUSE_ECALL   = 2'd1;
    localparam logic [1:0]  CAUSE_LOOP    = 2'd2;
    localparam logic [1:0]  CAUSE_TIMEOUT = 2'd3;

    localparam logic [31:0] ECALL_WORD    = 32'h0000_0073;

endpackage

// File: rtl/sim_run_controller_if.sv
// Retirement bus from the single-cycle core into the run controller.
interface sim_run_controller_if #(
    parameter int XLEN = 64
);
    logic            retire_valid;
    logic [XLEN-1:0] pc;
    logic [31:0]     instruction;
    logic [XLEN-1:0] alu_result;

    modport master (output retire_valid, pc, instruction, alu_result);
    modport slave  (input  retire_valid, pc, instruction, alu_result);
endinterface

// File: rtl/sim_trace_buf.sv
// Circular PC/instruction trace; read address is logical (0 = oldest valid entry).
module sim_trace_buf #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_clear,
    input  logic                     i_wr_en,
    input  logic [XLEN-1:0]          i_wr_pc,
    input  logic [31:0]              i_wr_instr,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [XLEN-1:0]          o_rd_pc,
    output logic [31:0]              o_rd_instr,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_wrapped
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = XLEN + 32;

    logic [EW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;
    logic          r_wrapped;
    logic [AW-1:0] w_rd_idx;
    logic [EW-1:0] w_rd_entry;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_wrapped <= 1'b0;
        end else if (i_clear) begin
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_wrapped <= 1'b0;
        end else if (i_wr_en) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            // once full, every write replaces the oldest entry
            if (r_count == (AW+1)'(DEPTH)) begin
                r_wrapped <= 1'b1;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[r_wr_ptr] <= {i_wr_pc, i_wr_instr};
        end
    end

    assign w_rd_idx   = (r_wrapped ? r_wr_ptr : '0) + i_rd_addr;
    assign w_rd_entry = r_mem[w_rd_idx];
    assign o_rd_pc    = w_rd_entry[EW-1:32];
    assign o_rd_instr = w_rd_entry[31:0];
    assign o_count    = r_count;
    assign o_wrapped  = r_wrapped;
endmodule

// File: rtl/sim_run_controller.sv
// Run controller: sequences core reset, detects end of program, counts and signs retires.
//   state    | meaning
//   IDLE     | after reset, waiting for start
//   RST_HOLD | core held in reset for RST_CYCLES+1 edges
//   RUN      | core released, counting cycles and retires
//   DONE     | halted, results frozen until next start
module sim_run_controller
    import sim_ctrl_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int CNT_W       = 32,
    parameter int RST_CYCLES  = 4,
    parameter int MAX_CYCLES  = 1024,
    parameter int TRACE_DEPTH = 16,
    parameter int LOOP_THRESH = 3
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic                           i_start,
    sim_run_controller_if.slave            rif,
    output logic                           o_core_reset_n,
    output logic                           o_running,
    output logic                           o_done,
    output logic [1:0]                     o_done_cause,
    output logic [CNT_W-1:0]               o_cycle_count,
    output logic [CNT_W-1:0]               o_instret_count,
    output logic [XLEN-1:0]                o_signature,
    output logic [$clog2(TRACE_DEPTH):0]   o_trace_count,
    output logic                           o_trace_wrapped,
    input  logic [$clog2(TRACE_DEPTH)-1:0] i_trace_rd_addr,
    output logic [XLEN-1:0]                o_trace_rd_pc,
    output logic [31:0]                    o_trace_rd_instr
);
    localparam int HW = $clog2(RST_CYCLES + 1);
    localparam int LW = $clog2(LOOP_THRESH);

    run_state_t       r_state;
    logic [HW-1:0]    r_hold_cnt;
    logic             r_core_reset_n;
    logic             r_running;
    logic             r_done;
    logic [1:0]       r_done_cause;
    logic [CNT_W-1:0] r_cycle_count;
    logic [CNT_W-1:0] r_instret;
    logic [XLEN-1:0]  r_signature;
    logic [XLEN-1:0]  r_prev_pc;
    logic             r_prev_valid;
    logic [LW-1:0]    r_loop_cnt;

    logic             w_start_acc;
    logic             w_retire;
    logic             w_pc_match;
    logic [LW-1:0]    w_loop_next;
    logic             w_halt_ecall;
    logic             w_halt_loop;
    logic             w_halt_timeout;
    logic             w_halt;
    logic [1:0]       w_cause;

    assign w_start_acc    = i_start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_retire       = (r_state == S_RUN) && rif.retire_valid;
    assign w_pc_match     = w_retire && r_prev_valid && (rif.pc == r_prev_pc);
    assign w_loop_next    = w_pc_match ? r_loop_cnt + 1'b1 : '0;
    assign w_halt_ecall   = w_retire && (rif.instruction == ECALL_WORD);
    assign w_halt_loop    = w_pc_match && (w_loop_next == LW'(LOOP_THRESH - 1));
    assign w_halt_timeout = (r_state == S_RUN) && (r_cycle_count == CNT_W'(MAX_CYCLES - 1));
    assign w_halt         = w_halt_ecall || w_halt_loop || w_halt_timeout;

    always_comb begin
        w_cause = CAUSE_NONE;
        if (w_halt_ecall)        w_cause = CAUSE_ECALL;
        else if (w_halt_loop)    w_cause = CAUSE_LOOP;
        else if (w_halt_timeout) w_cause = CAUSE_TIMEOUT;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state        <= S_IDLE;
            r_hold_cnt     <= '0;
            r_core_reset_n <= 1'b0;
            r_running      <= 1'b0;
            r_done         <= 1'b0;
            r_done_cause   <= CAUSE_NONE;
            r_cycle_count  <= '0;
            r_instret      <= '0;
            r_signature    <= '0;
            r_prev_pc      <= '0;
            r_prev_valid   <= 1'b0;
            r_loop_cnt     <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_state       <= S_RST_HOLD;
                        r_hold_cnt    <= HW'(RST_CYCLES);
                        r_done        <= 1'b0;
                        r_done_cause  <= CAUSE_NONE;
                        r_cycle_count <= '0;
                        r_instret     <= '0;
                        r_signature   <= '0;
                        r_prev_valid  <= 1'b0;
                        r_loop_cnt    <= '0;
                    end
                end
                S_RST_HOLD: begin
                    if (r_hold_cnt == '0) begin
                        r_state        <= S_RUN;
                        r_core_reset_n <= 1'b1;
                        r_running      <= 1'b1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 1'b1;
                    end
                end
                S_RUN: begin
                    if (r_cycle_count != '1) r_cycle_count <= r_cycle_count + 1'b1;
                    if (rif.retire_valid) begin
                        if (r_instret != '1) r_instret <= r_instret + 1'b1;
                        r_signature  <= {r_signature[XLEN-2:0], r_signature[XLEN-1]} ^ rif.alu_result;
                        r_prev_pc    <= rif.pc;
                        r_prev_valid <= 1'b1;
                        r_loop_cnt   <= w_loop_next;
                    end
                    // the halting retire is still counted and signed above
                    if (w_halt) begin
                        r_state        <= S_DONE;
                        r_core_reset_n <= 1'b0;
                        r_running      <= 1'b0;
                        r_done         <= 1'b1;
                        r_done_cause   <= w_cause;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    sim_trace_buf #(
        .XLEN  (XLEN),
        .DEPTH (TRACE_DEPTH)
    ) u_trace (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clear    (w_start_acc),
        .i_wr_en    (w_retire),
        .i_wr_pc    (rif.pc),
        .i_wr_instr (rif.instruction),
        .i_rd_addr  (i_trace_rd_addr),
        .o_rd_pc    (o_trace_rd_pc),
        .o_rd_instr (o_trace_rd_instr),
        .o_count    (o_trace_count),
        .o_wrapped  (o_trace_wrapped)
    );

    assign o_core_reset_n  = r_core_reset_n;
    assign o_running       = r_running;
    assign o_done          = r_done;
    assign o_done_cause    = r_done_cause;
    assign o_cycle_count   = r_cycle_count;
    assign o_instret_count = r_instret;
    assign o_signature     = r_signature;
endmodule

// File: tb/tb_sim_run_controller.sv
// Bench for sim_run_controller: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue-based behavioural model.
module tb_sim_run_controller;
    localparam int XLEN        = 64;
    localparam int CNT_W       = 32;
    localparam int RST_CYCLES  = 4;
    localparam int MAX_CYCLES  = 24;
    localparam int TRACE_DEPTH = 16;
    localparam int LOOP_THRESH = 3;
    localparam int AW          = $clog2(TRACE_DEPTH);

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] ECALL = 32'h0000_0073;
    localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;

    localparam int P_IDLE = 0, P_HOLD = 1, P_RUN = 2, P_DONE = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic [AW-1:0] rd_addr = '0;

    logic                core_reset_n, running, done, trace_wrapped;
    logic [1:0]          done_cause;
    logic [CNT_W-1:0]    cycle_count, instret_count;
    logic [XLEN-1:0]     signature, trace_rd_pc;
    logic [AW:0]         trace_count;
    logic [31:0]         trace_rd_instr;

    int n_tests = 0;
    int n_fail  = 0;

    sim_run_controller_if #(.XLEN(XLEN)) rif();

    sim_run_controller #(
        .XLEN(XLEN), .CNT_W(CNT_W), .RST_CYCLES(RST_CYCLES), .MAX_CYCLES(MAX_CYCLES),
        .TRACE_DEPTH(TRACE_DEPTH), .LOOP_THRESH(LOOP_THRESH)
    ) dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_start          (start),
        .rif              (rif.slave),
        .o_core_reset_n   (core_reset_n),
        .o_running        (running),
        .o_done           (done),
        .o_done_cause     (done_cause),
        .o_cycle_count    (cycle_count),
        .o_instret_count  (instret_count),
        .o_signature      (signature),
        .o_trace_count    (trace_count),
        .o_trace_wrapped  (trace_wrapped),
        .i_trace_rd_addr  (rd_addr),
        .o_trace_rd_pc    (trace_rd_pc),
        .o_trace_rd_instr (trace_rd_instr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int              m_phase = P_IDLE;
    int              m_wait = 0;
    longint unsigned m_cycles = 0, m_instret = 0;
    logic [63:0]     m_sig = '0;
    logic [1:0]      m_cause = '0;
    logic [63:0]     q_pc[$];
    logic [31:0]     q_in[$];
    bit              m_wrapped = 0;
    logic [63:0]     m_prev_pc = '0;
    bit              m_prev_valid = 0;
    int              m_rep = 0;

    task automatic model_clear();
        m_cycles = 0; m_instret = 0; m_sig = '0; m_cause = 2'd0;
        q_pc.delete(); q_in.delete(); m_wrapped = 0;
        m_prev_valid = 0; m_rep = 0;
    endtask

    task automatic model_step(input bit rst_n, input bit st, input bit rv,
                              input logic [63:0] p, input logic [31:0] ins, input logic [63:0] alu);
        bit timeout, ec, lp;
        if (!rst_n) begin
            m_phase = P_IDLE;
            model_clear();
            return;
        end
        case (m_phase)
            P_IDLE, P_DONE: if (st) begin
                model_clear();
                m_phase = P_HOLD;
                m_wait  = RST_CYCLES;
            end
            P_HOLD: if (m_wait == 0) m_phase = P_RUN; else m_wait--;
            default: begin
                timeout = (m_cycles == longint'(MAX_CYCLES - 1));
                ec = 0; lp = 0;
                if (m_cycles < CNT_MAX) m_cycles++;
                if (rv) begin
                    if (m_instret < CNT_MAX) m_instret++;
                    if (q_pc.size() == TRACE_DEPTH) begin
                        void'(q_pc.pop_front());
                        void'(q_in.pop_front());
                        m_wrapped = 1;
                    end
                    q_pc.push_back(p);
                    q_in.push_back(ins);
                    m_sig = ((m_sig << 1) | (m_sig >> 63)) ^ alu;
                    if (m_prev_valid && p == m_prev_pc) m_rep++; else m_rep = 0;
                    m_prev_pc = p; m_prev_valid = 1;
                    ec = (ins == ECALL);
                    lp = (m_rep >= LOOP_THRESH - 1);
                end
                if (ec)           begin m_cause = 2'd1; m_phase = P_DONE; end
                else if (lp)      begin m_cause = 2'd2; m_phase = P_DONE; end
                else if (timeout) begin m_cause = 2'd3; m_phase = P_DONE; end
            end
        endcase
    endtask

    task automatic compare();
        check("core_reset_n", 64'(core_reset_n), 64'(m_phase == P_RUN));
        check("running", 64'(running), 64'(m_phase == P_RUN));
        check("done", 64'(done), 64'(m_phase == P_DONE));
        check("done_cause", 64'(done_cause), 64'(m_cause));
        check("cycle_count", 64'(cycle_count), m_cycles);
        check("instret_count", 64'(instret_count), m_instret);
        check("signature", signature, m_sig);
        check("trace_count", 64'(trace_count), 64'(q_pc.size()));
        check("trace_wrapped", 64'(trace_wrapped), 64'(m_wrapped));
        if (int'(rd_addr) < q_pc.size()) begin
            check("trace_rd_pc", trace_rd_pc, q_pc[rd_addr]);
            check("trace_rd_instr", 64'(trace_rd_instr), 64'(q_in[rd_addr]));
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step(reset, start, rif.retire_valid, rif.pc, rif.instruction, rif.alu_result);
            @(negedge clk);
            compare();
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic retire(input logic [63:0] p, input logic [31:0] ins, input logic [63:0] alu);
        rif.retire_valid = 1'b1; rif.pc = p; rif.instruction = ins; rif.alu_result = alu;
        tick();
        rif.retire_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (RST_CYCLES + 1) tick();
    endtask

    initial begin
        rif.retire_valid = 1'b0; rif.pc = '0; rif.instruction = '0; rif.alu_result = '0;
        repeat (3) tick();
        check("rst_running", 64'(running), 64'd0);
        check("rst_core_reset_n", 64'(core_reset_n), 64'd0);
        check("rst_done_cause", 64'(done_cause), 64'd0);
        check("rst_trace_count", 64'(trace_count), 64'd0);
        reset = 1'b1;
        tick();

        // start latency: running rises after edge t+1+RST_CYCLES
        start = 1'b1;
        tick();
        start = 1'b0;
        check("hold_t0_core_reset_n", 64'(core_reset_n), 64'd0);
        for (int i = 1; i <= RST_CYCLES; i++) begin
            tick();
            check("hold_running", 64'(running), 64'd0);
        end
        tick();
        check("run_entry_running", 64'(running), 64'd1);
        check("run_entry_core_reset_n", 64'(core_reset_n), 64'd1);

        // five retires then ecall
        for (int i = 0; i < 5; i++) retire(64'(i * 4 + 0), NOP, 64'(i));
        retire(64'h14, ECALL, 64'd0);
        check("ecall_done", 64'(done), 64'd1);
        check("ecall_cause", 64'(done_cause), 64'd1);
        check("ecall_instret", 64'(instret_count), 64'd6);
        check("ecall_cycles", 64'(cycle_count), 64'd6);
        check("ecall_trace_count", 64'(trace_count), 64'd6);
        rd_addr = '0; #1;
        check("ecall_trace_pc0", trace_rd_pc, 64'h0);

        // restart from DONE, ignored start in RUN, then self-loop
        do_start();
        check("restart_cycles", 64'(cycle_count), 64'd0);
        check("restart_cause", 64'(done_cause), 64'd0);
        check("restart_trace_count", 64'(trace_count), 64'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_in_run_running", 64'(running), 64'd1);
        check("start_in_run_cycles", 64'(cycle_count), 64'd1);
        retire(64'h40, NOP, 64'd7);
        retire(64'h40, NOP, 64'd7);
        check("loop_not_yet", 64'(done), 64'd0);
        retire(64'h40, NOP, 64'd7);
        check("loop_cause", 64'(done_cause), 64'd2);
        check("loop_instret", 64'(instret_count), 64'd3);
        check("loop_cycles", 64'(cycle_count), 64'd4);

        // timeout with no retires
        do_start();
        repeat (MAX_CYCLES - 1) tick();
        check("pre_timeout_running", 64'(running), 64'd1);
        tick();
        check("timeout_cause", 64'(done_cause), 64'd3);
        check("timeout_cycles", 64'(cycle_count), 64'(MAX_CYCLES));

        // signature and trace wrap over 20 retires
        do_start();
        for (int i = 0; i < 20; i++) begin
            retire(64'(i * 4), NOP, (i < 3) ? (64'd1 << i) : {$urandom, $urandom});
            if (i == 2) check("signature_1_2_4", signature, 64'h4);
        end
        check("wrap_flag", 64'(trace_wrapped), 64'd1);
        check("wrap_count", 64'(trace_count), 64'd16);
        rd_addr = 4'd0; #1;
        check("wrap_pc_oldest", trace_rd_pc, 64'h10);
        rd_addr = 4'd15; #1;
        check("wrap_pc_newest", trace_rd_pc, 64'h4C);

        // reset mid-run, then a fresh run
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("midrst_running", 64'(running), 64'd0);
        check("midrst_instret", 64'(instret_count), 64'd0);
        check("midrst_signature", signature, 64'd0);
        check("midrst_wrapped", 64'(trace_wrapped), 64'd0);
        do_start();
        retire(64'h100, NOP, 64'd5);
        check("fresh_instret", 64'(instret_count), 64'd1);
        check("fresh_cycles", 64'(cycle_count), 64'd1);
        check("fresh_signature", signature, 64'd5);

        // randomized traffic, checked every cycle by the model
        for (int c = 0; c < 3000; c++) begin
            reset            = ($urandom_range(0, 199) != 0);
            start            = ($urandom_range(0, 9) == 0);
            rif.retire_valid = ($urandom_range(0, 2) != 0);
            rif.pc           = 64'($urandom_range(0, 3)) * 64'd4;
            rif.instruction  = ($urandom_range(0, 29) == 0) ? ECALL : NOP;
            rif.alu_result   = {$urandom, $urandom};
            rd_addr          = AW'($urandom_range(0, TRACE_DEPTH - 1));
            tick();
        end
        reset = 1'b1; start = 1'b0; rif.retire_valid = 1'b0;
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sim_run_controller.md
Name: sim_run_controller

Overview:
Parametrised run controller and retirement monitor for the single-cycle RISC-V datapath in simulation and FPGA bring-up. It sequences the core reset and detects end of program by ECALL, PC self-loop or cycle timeout. While the core runs, it counts cycles and retired instructions, keeps a circular PC/instruction trace and folds ALU results into a regression signature. It replaces free-running fixed-time benches with a deterministic, self-terminating run.

Parameters:
XLEN, 64, datapath width of pc and alu_result
CNT_W, 32, width of cycle/instret counters
RST_CYCLES, 4, cycles core_reset_n is held low before RUN (>=1)
MAX_CYCLES, 1024, RUN cycles before timeout (>=1, < 2^CNT_W)
TRACE_DEPTH, 16, trace entries (power of 2, >=2)
LOOP_THRESH, 3, consecutive retires at an unchanged pc that declare a self-loop (>=2)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
start  in  1  pulse; begins a run from IDLE or DONE
retire_valid  in  1  core retired an instruction this cycle
pc  in  XLEN  pc of the retiring instruction
instruction  in  32  retiring instruction word
alu_result  in  XLEN  ALU result of the retiring instruction
core_reset_n  out  1  registered reset to datapath; high only in RUN
running  out  1  state==RUN
done  out  1  state==DONE
done_cause  out  2  0 none, 1 ecall, 2 loop, 3 timeout
cycle_count  out  CNT_W  cycles spent in RUN
instret_count  out  CNT_W  accepted retires
signature  out  XLEN  result checksum
trace_count  out  log2(TRACE_DEPTH)+1  valid entries, saturates at TRACE_DEPTH
trace_wrapped  out  1  at least one entry overwritten
trace_rd_addr  in  log2(TRACE_DEPTH)  logical index, 0 = oldest valid entry
trace_rd_pc  out  XLEN  combinational read of pc field
trace_rd_instr  out  32  combinational read of instruction field

Behaviour:
- Reset (reset==0 at clk edge): state IDLE; core_reset_n=0; running=0; done=0; done_cause=0; counters, signature, trace_count, trace_wrapped, write pointer, loop counter=0. Trace memory contents are not reset.
- FSM IDLE -> RST_HOLD on start. RST_HOLD counts RST_CYCLES cycles, then -> RUN. RUN -> DONE on halt. DONE -> RST_HOLD on start.
- start is ignored in RST_HOLD and RUN.
- Start from DONE clears counters, signature, trace state and done_cause in the same edge that enters RST_HOLD.
- core_reset_n is registered and tracks the state: the edge entering RUN sets it to 1, and the edge leaving RUN clears it to 0.
- Latency: start sampled at edge t -> running=1 after edge t+1+RST_CYCLES.
- In RUN, every cycle: cycle_count+1, saturating.
- In RUN with retire_valid:
  - instret_count+1, saturating.
  - Trace entry {pc,instruction} written at wr_ptr; wr_ptr+1 mod TRACE_DEPTH.
  - trace_count+1 until TRACE_DEPTH; the write at full overwrites the oldest entry and sets trace_wrapped.
  - signature <= rotl(signature,1) ^ alu_result.
- retire_valid is ignored outside RUN.
- Read: physical index = (trace_wrapped ? wr_ptr : 0) + trace_rd_addr, mod TRACE_DEPTH. Reading addr >= trace_count returns stale data, no error.
- Halt conditions, evaluated in RUN on the current cycle's inputs:
  - ecall: retire_valid and instruction==32'h0000_0073.
  - loop: retire_valid and pc equals previous retired pc, and the loop counter reaches LOOP_THRESH-1. The loop counter resets to 0 on any pc change. The first retire of a run never matches.
  - timeout: cycle_count==MAX_CYCLES-1.
- On halt: the halting retire is still counted, traced and signed; next state DONE; done_cause set.
- Priority on simultaneous halts: ecall > loop > timeout.
- Reset mid-run: immediate return to IDLE with all outputs at reset values; no partial DONE.

Decomposition:
- Shared package sim_ctrl_pkg: state enum {IDLE,RST_HOLD,RUN,DONE}, done_cause constants, ECALL_WORD constant.
- One sub-module sim_trace_buf: circular buffer with write port, wr_ptr/count/wrapped tracking and logical-address combinational read.

Test Plan:
- Reset then start, RST_CYCLES=4 -> core_reset_n low 4 cycles after start, then high; running=1 at edge t+5.
- Retire 5 distinct pcs, then ecall at pc 0x14 -> done=1, done_cause=1, instret_count=6, cycle_count=6, trace_count=6, trace_rd_pc(0)=first pc.
- Feed pc 0x40 repeatedly, LOOP_THRESH=3 -> done_cause=2 on the 3rd retire at 0x40; that retire is still counted.
- retire_valid=0 throughout, MAX_CYCLES=10 -> done_cause=3 with cycle_count=10.
- Signature: alu_result 1, 2, 4 -> signature = 0x...0002^... = ((1<<<1)^2)<<<1 ^ 4 = 0x4.
- 20 retires (pc 0..19 step 4) with TRACE_DEPTH=16 -> trace_wrapped=1, trace_count=16, trace_rd_pc(0)=0x10, trace_rd_pc(15)=0x4C.
- Assert reset during RUN, then start again -> outputs return to zero, then a fresh run with counters from 0.
- start asserted during RUN -> ignored, no change in counters.
